fetch_control: RTL and testbench
================================

# fetch_control

Pipeline control block that sequences the instruction-fetch stage. It generates the stall, flush and bubble controls for the PC register, IF/ID and ID/EX in response to:
- load-use hazards
- taken branches and jumps
- instruction-memory wait states
- HALT

It also keeps saturating stall/flush statistics and raises a fault on an instruction-memory timeout.

## Interface
Parameters:
- REG_W, 3, register-address width
- TIMEOUT, 15, max consecutive imem-not-ready cycles before fault
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  Signal type; asynchronous, active-high (ENABLE)
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_W each  ID source registers
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  REG_W  EX load destination
- ex_branch_taken  in  1  EX branch & alu_zero
- id_jmp  in  1  ID is an unconditional jump
- id_halt  in  1  ID is HALT
- imem_ready  in  1  instruction memory returned valid data this cycle
- if_stall  out  1  hold PC (drives IF stall)
- ifid_hold  out  1  hold IF/ID register
- ifid_flush  out  1  zero IF/ID next edge
- idex_bubble  out  1  insert NOP into ID/EX next edge
- halted  out  1  core halted
- fault  out  1  imem timeout, sticky
- stall_cycles  out  CNT_W  saturating count of cycles with if_stall=1
- flush_count  out  CNT_W  saturating count of ifid_flush pulses

## Operation
- The state register is FetchState with states RUN, LU_STALL, MEM_WAIT, HALTED and FAULT. Outputs are a combinational (Mealy) function of state and inputs.
- Load-use hazard condition (lu):
  - ex_mem_read & id_valid & (ex_rd != 0), and
  - (ex_rd == id_rs | (id_uses_rt & ex_rd == id_rt)).
- Priority in RUN: ex_branch_taken > id_jmp > id_halt > lu > !imem_ready.
  - ex_branch_taken: ifid_flush=1, idex_bubble=1, no stall. The IF block itself selects pc_branch. Stay in RUN.
  - id_jmp: ifid_flush=1. Stay in RUN.
  - id_halt: if_stall=1, ifid_hold=1. Go to HALTED.
  - lu: if_stall=1, ifid_hold=1, idex_bubble=1. Go to LU_STALL.
  - !imem_ready: if_stall=1, idex_bubble=1 (IF/ID is not valid). Go to MEM_WAIT and load the wait counter with 1.
- LU_STALL:
  - No stall outputs. Go to RUN next cycle, giving a single-cycle bubble.
  - ex_branch_taken in this state still flushes.
- MEM_WAIT:
  - While imem_ready=0: if_stall=1, idex_bubble=1, increment the wait counter.
  - When the counter reaches TIMEOUT, go to FAULT.
  - When imem_ready=1, go to RUN.
  - ex_branch_taken while waiting: assert ifid_flush=1, stay in MEM_WAIT.
- HALTED: if_stall=1, ifid_hold=1 and halted=1 forever. Only reset exits.
- FAULT: same outputs as HALTED, plus fault=1. Only reset exits.
- Statistics counters saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, immediate):
  - state is RUN
  - wait counter = 0, stall_cycles = 0, flush_count = 0
  - halted = 0, fault = 0
  - During reset all control outputs are 0.
- Hazard controls are valid in the same cycle as the triggering inputs; they take effect at the next rising edge.
- Load-use costs exactly one bubble cycle.
- Branch or jump costs one flushed IF/ID slot, with zero stall cycles.
- Timeout: fault asserts on the edge after TIMEOUT consecutive not-ready cycles.
- Reset deasserted mid-MEM_WAIT or mid-HALTED restarts cleanly in RUN.

## Structure
- Add to the definitions package:
  - FetchState enum
  - FetchCtl struct (if_stall, ifid_hold, ifid_flush, idex_bubble) so IF/ID stage wrappers take it whole
  - HAZ_REG_ZERO constant
- Sub-module hazard_detect: purely combinational lu compare, reusable by a later forwarding unit.
- fetch_control holds the FSM, the wait counter and the statistics counters.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=2, id_rs=2 → one cycle of if_stall=1, idex_bubble=1, then RUN; stall_cycles=1. Repeat with ex_rd=0 → no stall.
- Branch and load-use in the same cycle (ex_branch_taken=1, lu=1) → ifid_flush=1, idex_bubble=1, if_stall=0, state stays RUN; flush_count=1.
- imem_ready low for 3 cycles → if_stall=1 for those 3 cycles, RUN on the 4th; fault=0.
- imem_ready held low, TIMEOUT=15 → fault=1 after 15 cycles and stays 1; asserting reset clears fault and halted asynchronously.
- id_halt=1 → halted=1 and if_stall=1 indefinitely; a subsequent id_jmp is ignored.
- Counter saturation with CNT_W=4: 20 stall cycles → stall_cycles=15.

Source files
------------

// File: rtl/fetch_control_pkg.sv
// ============================================================================
// Module   : fetch_control_pkg
// Purpose  : Shared definitions for the fetch-control slice. It holds the FSM
//            state encoding, the bundled pipeline-control struct that IF/ID
//            wrappers take whole, and the hardwired-zero register index.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_control_pkg;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LU_STALL = 3'd1,
    MEM_WAIT = 3'd2,
    HALTED   = 3'd3,
    FAULT    = 3'd4
  } FetchState;

  // Pipeline control bundle for the PC / IF/ID / ID/EX registers
  typedef struct packed {
    logic if_stall;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_bubble;
  } FetchCtl;

  // Register 0 is hardwired to zero, so a load into it can never create a hazard
  localparam int unsigned HAZ_REG_ZERO = 0;

endpackage

`default_nettype wire

// File: rtl/fetch_control_if.sv
// ============================================================================
// Module   : fetch_control_if
// Purpose  : Bundles the hazard inputs and the pipeline-control outputs that
//            pass between the pipeline datapath and fetch_control.
// Ports    : master - pipeline side (drives hazard info, reads controls)
//            slave  - fetch_control side (reads hazard info, drives controls)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_control_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             id_jmp;
  logic             id_halt;
  logic             imem_ready;
  logic             if_stall;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           ex_branch_taken, id_jmp, id_halt, imem_ready,
    input  if_stall, ifid_hold, ifid_flush, idex_bubble, halted, fault,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           ex_branch_taken, id_jmp, id_halt, imem_ready,
    output if_stall, ifid_hold, ifid_flush, idex_bubble, halted, fault,
           stall_cycles, flush_count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_control_hazard_detect.sv
// ============================================================================
// Module   : fetch_control_hazard_detect
// Purpose  : Purely combinational load-use hazard compare between the load in
//            EX and the source registers of the instruction in ID.
// Ports    : ex_mem_read, ex_rd            - EX load and its destination
//            id_valid, id_rs, id_rt,
//            id_uses_rt                    - ID instruction source operands
//            lu                            - load-use hazard present
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_control_hazard_detect
  import fetch_control_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  wire logic             ex_mem_read,
  input  wire logic [REG_W-1:0] ex_rd,
  input  wire logic             id_valid,
  input  wire logic [REG_W-1:0] id_rs,
  input  wire logic [REG_W-1:0] id_rt,
  input  wire logic             id_uses_rt,
  output logic                  lu
);

  logic w_rd_nonzero;
  logic w_src_match;

  assign w_rd_nonzero = (ex_rd != REG_W'(HAZ_REG_ZERO));
  // rt only matters when the ID instruction actually reads it
  assign w_src_match  = (ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt));
  assign lu           = ex_mem_read & id_valid & w_rd_nonzero & w_src_match;

endmodule

`default_nettype wire

// File: rtl/fetch_control.sv
// ============================================================================
// Module   : fetch_control
// Purpose  : Sequences the instruction-fetch stage. Produces PC stall, IF/ID
//            hold/flush and ID/EX bubble controls for load-use hazards, taken
//            branches, jumps, imem wait states and HALT; counts stall cycles
//            and flushes (saturating); flags a sticky imem-timeout fault.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - fetch_control_if.slave (hazard inputs, control outputs,
//                   halted/fault status, statistics counters)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_control
  import fetch_control_pkg::*;
#(
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input wire logic      clk,
  input wire logic      rst,
  fetch_control_if.slave bus
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  FetchState         r_state;
  FetchState         w_next;
  FetchCtl           w_ctl;
  logic              w_halted;
  logic              w_fault;
  logic              w_lu;
  logic              w_wait_last;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_count;

  fetch_control_hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_valid    (bus.id_valid),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .lu          (w_lu)
  );

  // The counter holds the number of not-ready cycles already seen; this cycle
  // being not-ready as well completes TIMEOUT of them.
  assign w_wait_last = (r_wait_cnt >= WAIT_W'(TIMEOUT - 1));

  always_comb begin
    w_ctl    = '0;
    w_next   = r_state;
    w_halted = 1'b0;
    w_fault  = 1'b0;
    unique case (r_state)
      RUN: begin
        if (bus.ex_branch_taken) begin
          w_ctl.ifid_flush  = 1'b1;
          w_ctl.idex_bubble = 1'b1;
        end else if (bus.id_jmp) begin
          w_ctl.ifid_flush  = 1'b1;
        end else if (bus.id_halt) begin
          w_ctl.if_stall    = 1'b1;
          w_ctl.ifid_hold   = 1'b1;
          w_next            = HALTED;
        end else if (w_lu) begin
          w_ctl.if_stall    = 1'b1;
          w_ctl.ifid_hold   = 1'b1;
          w_ctl.idex_bubble = 1'b1;
          w_next            = LU_STALL;
        end else if (!bus.imem_ready) begin
          // IF/ID content is not valid, so it is not held; ID/EX gets a NOP
          w_ctl.if_stall    = 1'b1;
          w_ctl.idex_bubble = 1'b1;
          w_next            = (TIMEOUT <= 1) ? FAULT : MEM_WAIT;
        end
      end
      LU_STALL: begin
        // The bubble is already in EX; release the pipeline next cycle
        if (bus.ex_branch_taken) begin
          w_ctl.ifid_flush  = 1'b1;
          w_ctl.idex_bubble = 1'b1;
        end
        w_next = RUN;
      end
      MEM_WAIT: begin
        if (bus.ex_branch_taken) begin
          w_ctl.ifid_flush = 1'b1;
        end
        if (bus.imem_ready) begin
          w_next = RUN;
        end else begin
          w_ctl.if_stall    = 1'b1;
          w_ctl.idex_bubble = 1'b1;
          w_next            = w_wait_last ? FAULT : MEM_WAIT;
        end
      end
      HALTED: begin
        w_ctl.if_stall  = 1'b1;
        w_ctl.ifid_hold = 1'b1;
        w_halted        = 1'b1;
      end
      FAULT: begin
        w_ctl.if_stall  = 1'b1;
        w_ctl.ifid_hold = 1'b1;
        w_halted        = 1'b1;
        w_fault         = 1'b1;
      end
      default: begin
        w_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_next;

      if (w_next != MEM_WAIT) begin
        r_wait_cnt <= '0;
      end else if (r_state != MEM_WAIT) begin
        r_wait_cnt <= WAIT_W'(1);
      end else begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end

      if (w_ctl.if_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_ctl.ifid_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  // Controls are forced low while reset is held, independent of inputs
  assign bus.if_stall     = w_ctl.if_stall    & ~rst;
  assign bus.ifid_hold    = w_ctl.ifid_hold   & ~rst;
  assign bus.ifid_flush   = w_ctl.ifid_flush  & ~rst;
  assign bus.idex_bubble  = w_ctl.idex_bubble & ~rst;
  assign bus.halted       = w_halted          & ~rst;
  assign bus.fault        = w_fault           & ~rst;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_control.sv
// ============================================================================
// Module   : tb_fetch_control
// Purpose  : Directed self-checking bench for fetch_control (TIMEOUT=15,
//            CNT_W=4 so counter saturation is reachable quickly).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_control;

  localparam int REG_W   = 3;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  fetch_control_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  fetch_control #(
    .REG_W   (REG_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {if_stall, ifid_hold, ifid_flush, idex_bubble}
  logic [3:0] ctl;
  assign ctl = {bus.if_stall, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble};

  task automatic idle_inputs;
    bus.id_valid        = 1'b0;
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.id_uses_rt      = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_rd           = '0;
    bus.ex_branch_taken = 1'b0;
    bus.id_jmp          = 1'b0;
    bus.id_halt         = 1'b0;
    bus.imem_ready      = 1'b1;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.imem_ready = 1'b0;
    bus.id_halt    = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ctl, bus.halted, bus.fault} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected %b", {ctl, bus.halted, bus.fault}, 6'b000000);
    end
    next_cycle();
    vectors++;
    if ({bus.stall_cycles, bus.flush_count} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_counters: got %h expected %h", {bus.stall_cycles, bus.flush_count}, 8'h00);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load_use;
    do_reset();
    bus.id_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd2;
    bus.id_rs = 3'd2; bus.id_rt = 3'd5;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1101) begin
      miscompares++; $display("FAIL lu_rs_ctl: got %b expected %b", ctl, 4'b1101);
    end
    next_cycle();
    vectors++;
    if (bus.stall_cycles !== 4'd1) begin
      miscompares++; $display("FAIL lu_stall_count: got %0d expected %0d", bus.stall_cycles, 1);
    end
    // In LU_STALL nothing stalls, even with imem not ready
    bus.ex_mem_read = 1'b0; bus.imem_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++; $display("FAIL lu_bubble_cycle: got %b expected %b", ctl, 4'b0000);
    end
    next_cycle();
    bus.imem_ready = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd0; bus.id_rs = 3'd0;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++; $display("FAIL lu_rd_zero: got %b expected %b", ctl, 4'b0000);
    end
    next_cycle();
    bus.ex_rd = 3'd3; bus.id_rs = 3'd1; bus.id_rt = 3'd3; bus.id_uses_rt = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++; $display("FAIL lu_rt_unused: got %b expected %b", ctl, 4'b0000);
    end
    next_cycle();
    bus.id_uses_rt = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1101) begin
      miscompares++; $display("FAIL lu_rt_ctl: got %b expected %b", ctl, 4'b1101);
    end
    next_cycle();
    bus.ex_mem_read = 1'b0;
    next_cycle();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd2; bus.id_rs = 3'd2; bus.id_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++; $display("FAIL lu_id_invalid: got %b expected %b", ctl, 4'b0000);
    end
    vectors++;
    if (bus.stall_cycles !== 4'd2) begin
      miscompares++; $display("FAIL lu_stall_total: got %0d expected %0d", bus.stall_cycles, 2);
    end
    next_cycle();
  endtask

  task automatic test_branch_jump;
    do_reset();
    bus.ex_branch_taken = 1'b1;
    bus.id_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd2; bus.id_rs = 3'd2;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0011) begin
      miscompares++; $display("FAIL branch_lu_ctl: got %b expected %b", ctl, 4'b0011);
    end
    next_cycle();
    vectors++;
    if ({bus.flush_count, bus.stall_cycles} !== {4'd1, 4'd0}) begin
      miscompares++; $display("FAIL branch_counts: got %h expected %h", {bus.flush_count, bus.stall_cycles}, 8'h10);
    end
    // Still in RUN: an imem miss stalls immediately
    idle_inputs(); bus.imem_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1001) begin
      miscompares++; $display("FAIL branch_stays_run: got %b expected %b", ctl, 4'b1001);
    end
    next_cycle();
    bus.imem_ready = 1'b1;
    next_cycle();
    bus.id_jmp = 1'b1; bus.id_halt = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0010) begin
      miscompares++; $display("FAIL jmp_ctl: got %b expected %b", ctl, 4'b0010);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if ({ctl, bus.halted, bus.flush_count} !== {4'b0000, 1'b0, 4'd2}) begin
      miscompares++; $display("FAIL jmp_after: got %b expected %b", {ctl, bus.halted, bus.flush_count}, 9'b000000010);
    end
    next_cycle();
  endtask

  task automatic test_mem_wait;
    do_reset();
    bus.imem_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1001) begin
      miscompares++; $display("FAIL memwait_c1: got %b expected %b", ctl, 4'b1001);
    end
    next_cycle();
    bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1011) begin
      miscompares++; $display("FAIL memwait_branch: got %b expected %b", ctl, 4'b1011);
    end
    next_cycle();
    bus.ex_branch_taken = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1001) begin
      miscompares++; $display("FAIL memwait_c3: got %b expected %b", ctl, 4'b1001);
    end
    next_cycle();
    bus.imem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ctl, bus.fault} !== 5'b00000) begin
      miscompares++; $display("FAIL memwait_ready: got %b expected %b", {ctl, bus.fault}, 5'b00000);
    end
    next_cycle();
    vectors++;
    if ({bus.stall_cycles, bus.flush_count} !== {4'd3, 4'd1}) begin
      miscompares++; $display("FAIL memwait_counts: got %h expected %h", {bus.stall_cycles, bus.flush_count}, 8'h31);
    end
  endtask

  task automatic test_timeout;
    logic exp_f;
    do_reset();
    bus.imem_ready = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.if_stall !== 1'b1) begin
        miscompares++; $display("FAIL timeout_stall[%0d]: got %b expected 1", i, bus.if_stall);
      end
      next_cycle();
      exp_f = (i == TIMEOUT);
      vectors++;
      if (bus.fault !== exp_f) begin
        miscompares++; $display("FAIL timeout_fault[%0d]: got %b expected %b", i, bus.fault, exp_f);
      end
    end
    bus.imem_ready = 1'b1; bus.id_jmp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({ctl, bus.halted, bus.fault} !== 6'b110011) begin
        miscompares++; $display("FAIL fault_sticky: got %b expected %b", {ctl, bus.halted, bus.fault}, 6'b110011);
      end
      next_cycle();
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ctl, bus.halted, bus.fault} !== 6'b000000) begin
      miscompares++; $display("FAIL fault_async_clear: got %b expected %b", {ctl, bus.halted, bus.fault}, 6'b000000);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({ctl, bus.fault} !== 5'b00000) begin
      miscompares++; $display("FAIL fault_restart: got %b expected %b", {ctl, bus.fault}, 5'b00000);
    end
    next_cycle();
  endtask

  task automatic test_halt_saturation;
    do_reset();
    bus.id_halt = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ctl, bus.halted} !== 5'b11000) begin
      miscompares++; $display("FAIL halt_entry: got %b expected %b", {ctl, bus.halted}, 5'b11000);
    end
    next_cycle();
    bus.id_halt = 1'b0; bus.id_jmp = 1'b1;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      vectors++;
      if ({ctl, bus.halted} !== 5'b11001) begin
        miscompares++; $display("FAIL halt_hold[%0d]: got %b expected %b", k, {ctl, bus.halted}, 5'b11001);
      end
      next_cycle();
      if (k == 14) begin
        vectors++;
        if (bus.stall_cycles !== 4'd14) begin
          miscompares++; $display("FAIL stall_count_14: got %0d expected %0d", bus.stall_cycles, 14);
        end
      end
    end
    vectors++;
    if ({bus.stall_cycles, bus.flush_count} !== {4'd15, 4'd0}) begin
      miscompares++; $display("FAIL stall_saturate: got %h expected %h", {bus.stall_cycles, bus.flush_count}, 8'hF0);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.halted, bus.if_stall, bus.stall_cycles} !== 6'b000000) begin
      miscompares++; $display("FAIL halt_async_clear: got %b expected %b", {bus.halted, bus.if_stall, bus.stall_cycles}, 6'b000000);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch_jump();
    test_mem_wait();
    test_timeout();
    test_halt_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
